// File: rtl/mips_cpu_divider.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Results land in LO (quotient) and HI (remainder).
module mips_cpu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvd_sh_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dividend_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             signed_q;
  logic             zero_q;
  logic [WIDTH-1:0] res_quo_q;
  logic [WIDTH-1:0] res_rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH:0]   rem_sub_d;
  logic             rem_ge_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  always_comb begin
    a_neg_d     = is_signed & dividend[WIDTH-1];
    b_neg_d     = is_signed & divisor[WIDTH-1];
    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
    a_mag_d     = a_neg_d ? ('0 - dividend) : dividend;
    b_mag_d     = b_neg_d ? ('0 - divisor) : divisor;
    rem_shift_d = {rem_q[WIDTH-1:0], dvd_sh_q[WIDTH-1]};
    rem_sub_d   = rem_shift_d - {1'b0, dvs_q};
    rem_ge_d    = rem_shift_d >= {1'b0, dvs_q};
    quo_fix_d   = quo_q;
    rem_fix_d   = rem_q[WIDTH-1:0];
    if (zero_q) begin
      quo_fix_d = '1;
      rem_fix_d = dividend_q;
    end else if (signed_q) begin
      if (sign_a_q ^ sign_b_q) quo_fix_d = '0 - quo_q;
      if (sign_a_q)            rem_fix_d = '0 - rem_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_sh_q    <= '0;
      dvs_q       <= '0;
      dividend_q  <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      signed_q    <= 1'b0;
      zero_q      <= 1'b0;
      res_quo_q   <= '0;
      res_rem_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (clock_enable) begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CALC;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvd_sh_q   <= a_mag_d;
            dvs_q      <= b_mag_d;
            dividend_q <= dividend;
            sign_a_q   <= a_neg_d;
            sign_b_q   <= b_neg_d;
            signed_q   <= is_signed;
            zero_q     <= (divisor == '0);
          end
        end
        CALC: begin
          dvd_sh_q <= {dvd_sh_q[WIDTH-2:0], 1'b0};
          rem_q    <= rem_ge_d ? rem_sub_d : rem_shift_d;
          quo_q    <= {quo_q[WIDTH-2:0], rem_ge_d};
          if (cnt_q == 6'(WIDTH - 1)) state_q <= FIX;
          else                        cnt_q   <= cnt_q + 6'd1;
        end
        FIX: begin
          res_quo_q <= quo_fix_d;
          res_rem_q <= rem_fix_d;
          busy_q    <= 1'b0;
          state_q   <= DONE;
        end
        DONE: begin
          quotient_q  <= res_quo_q;
          remainder_q <= res_rem_q;
          dbz_q       <= zero_q;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
